// File: rtl/vga_scan_timing.sv
// VGA scan timing generator: pixel divider, h/v counters, sync/blank decode aligned to the display latency.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input that replaces display colour with 32 px colour bars.
module vga_scan_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIX_DIV  = 2,
    parameter int   DISP_LAT = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        red,
    input  logic        green,
    input  logic        blue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [31:0] row,
    output logic [31:0] col,
    output logic        vnotactive,
    output logic        pix_en,
    output logic        frame_tick,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PIX_DIV - 1);
    localparam logic [H_W-1:0]   H_MAX    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_MAX    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int SW = 6;
`else
    localparam int SW = 3;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q,  pix_en_d;
    logic [H_W-1:0]   h_cnt_q,   h_cnt_d;
    logic [V_W-1:0]   v_cnt_q,   v_cnt_d;
    logic             vna_q,     vna_d;
    logic             ftick_q,   ftick_d;
    logic             h_wrap, v_wrap;

    // pix_en is registered from the next divider value so it is low in reset
    // and coincides with div_cnt == PIX_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_W'(1);
        pix_en_d  = (div_cnt_d == DIV_MAX);
    end

    always_comb begin
        h_wrap  = (h_cnt_q == H_MAX);
        v_wrap  = (v_cnt_q == V_MAX);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        ftick_d = 1'b0;
        if (pix_en_q) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + H_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + V_W'(1);
                ftick_d = v_wrap;
            end
        end
        vna_d = (v_cnt_d >= V_ACT_C);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            vna_q     <= 1'b0;
            ftick_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            vna_q     <= vna_d;
            ftick_q   <= ftick_d;
        end
    end

    assign row        = {{(32-V_W){1'b0}}, v_cnt_q};
    assign col        = {{(32-H_W){1'b0}}, h_cnt_q};
    assign vnotactive = vna_q;
    assign pix_en     = pix_en_q;
    assign frame_tick = ftick_q;

    // Stage-0 decode, packed as {[pattern,] active, hs, vs}.
    logic          act_s0, hs_s0, vs_s0;
    logic [SW-1:0] stg_s0, stg_dly;

    always_comb begin
        act_s0 = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_s0  = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
        vs_s0  = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
`ifdef VGA_TEST_PATTERN_EN
        stg_s0 = {col[7:5], act_s0, hs_s0, vs_s0};
`else
        stg_s0 = {act_s0, hs_s0, vs_s0};
`endif
    end

    // Delay runs every CLK so it tracks the display stage's CLK-based latency.
    generate
        if (DISP_LAT == 0) begin : g_nodly
            assign stg_dly = stg_s0;
        end else begin : g_dly
            logic [DISP_LAT-1:0][SW-1:0] dly_q;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= stg_s0;
                    for (int i = 1; i < DISP_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign stg_dly = dly_q[DISP_LAT-1];
        end
    endgenerate

    logic [2:0] src_rgb, rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        src_rgb = {red, green, blue};
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) src_rgb = stg_dly[5:3];
`endif
        rgb_d = stg_dly[2] ? src_rgb : 3'b000;
        hs_d  = stg_dly[1] ? SYNC_POL : ~SYNC_POL;
        vs_d  = stg_dly[0] ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rgb_q <= 3'b000;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign VGA_R  = rgb_q[2];
    assign VGA_G  = rgb_q[1];
    assign VGA_B  = rgb_q[0];
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: full 640x480 instance for line timing, reduced-size instances for frame/divider checks.
module tb_vga_scan_timing;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic red = 1'b1, green = 1'b1, blue = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    always #5 CLK = ~CLK;

    logic [31:0] b_row, b_col, s_row, s_col, p_row, p_col;
    logic b_vna, b_pe, b_ft, b_r, b_g, b_b, b_hs, b_vs;
    logic s_vna, s_pe, s_ft, s_r, s_g, s_b, s_hs, s_vs;
    logic p_vna, p_pe, p_ft, p_r, p_g, p_b, p_hs, p_vs;

    vga_scan_timing u_big (
        .CLK(CLK), .RST(RST), .red(red), .green(green), .blue(blue),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .row(b_row), .col(b_col), .vnotactive(b_vna), .pix_en(b_pe), .frame_tick(b_ft),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs)
    );

    // Small frame: 25 x 10 pixels, 500 CLK per frame.
    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(2), .DISP_LAT(1), .SYNC_POL(1'b0)
    ) u_sml (
        .CLK(CLK), .RST(RST), .red(red), .green(green), .blue(blue),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .row(s_row), .col(s_col), .vnotactive(s_vna), .pix_en(s_pe), .frame_tick(s_ft),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs)
    );

    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(1), .DISP_LAT(1), .SYNC_POL(1'b0)
    ) u_p1 (
        .CLK(CLK), .RST(RST), .red(red), .green(green), .blue(blue),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .row(p_row), .col(p_col), .vnotactive(p_vna), .pix_en(p_pe), .frame_tick(p_ft),
        .VGA_R(p_r), .VGA_G(p_g), .VGA_B(p_b), .VGA_HS(p_hs), .VGA_VS(p_vs)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string who);
        chk({who, "_row_b"}, b_row, 0);   chk({who, "_col_b"}, b_col, 0);
        chk({who, "_vna_b"}, 32'(b_vna), 0); chk({who, "_pe_b"}, 32'(b_pe), 0);
        chk({who, "_ft_b"}, 32'(b_ft), 0);
        chk({who, "_rgb_b"}, 32'({b_r, b_g, b_b}), 0);
        chk({who, "_hs_b"}, 32'(b_hs), 1); chk({who, "_vs_b"}, 32'(b_vs), 1);
        chk({who, "_row_s"}, s_row, 0);   chk({who, "_col_s"}, s_col, 0);
        chk({who, "_rgb_s"}, 32'({s_r, s_g, s_b}), 0);
        chk({who, "_vs_s"}, 32'(s_vs), 1); chk({who, "_pe_p"}, 32'(p_pe), 0);
    endtask

    // Counter position after k rising edges since reset release (PIX_DIV = 2).
    function automatic int bcol(input int k); return (k / 2) % 800; endfunction
    function automatic int brow(input int k); return ((k / 2) / 800) % 525; endfunction
    function automatic int scol(input int k); return (k / 2) % 25; endfunction
    function automatic int srow(input int k); return ((k / 2) / 25) % 10; endfunction

    int hs_low_cnt = 0;
    int hs_first   = -1;
    int ft_cnt     = 0;

    initial begin
        @(negedge CLK);
        chk_reset("rst");
        @(negedge CLK);
        RST = 1'b1;

        for (int k = 1; k <= 1700; k++) begin
            logic [2:0] exp_rgb, pat;
            logic       tm;
            int         c2, r2;
            @(negedge CLK);

            chk($sformatf("b_col@%0d", k), b_col, bcol(k));
            chk($sformatf("b_row@%0d", k), b_row, brow(k));
            chk($sformatf("b_pe@%0d", k), 32'(b_pe), (k % 2));

            c2 = (k >= 2) ? bcol(k - 2) : 0;
            r2 = (k >= 2) ? brow(k - 2) : 0;
            tm = (k >= 181) && (k <= 200);
            pat = 3'(c2 >> 5);
`ifdef VGA_TEST_PATTERN_EN
            exp_rgb = tm ? pat : 3'b111;
`else
            exp_rgb = 3'b111;
`endif
            if (!(k >= 2 && c2 < 640 && r2 < 480)) exp_rgb = 3'b000;
            chk($sformatf("b_rgb@%0d", k), 32'({b_r, b_g, b_b}), 32'(exp_rgb));
            chk($sformatf("b_hs@%0d", k), 32'(b_hs), (k >= 2 && c2 >= 656 && c2 <= 751) ? 0 : 1);
            if (b_hs == 1'b0) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = k;
            end

            c2 = (k >= 2) ? scol(k - 2) : 0;
            r2 = (k >= 2) ? srow(k - 2) : 0;
            chk($sformatf("s_col@%0d", k), s_col, scol(k));
            chk($sformatf("s_row@%0d", k), s_row, srow(k));
            chk($sformatf("s_vna@%0d", k), 32'(s_vna), (srow(k) >= 6) ? 1 : 0);
            chk($sformatf("s_ft@%0d", k), 32'(s_ft), (k % 500 == 0) ? 1 : 0);
            chk($sformatf("s_rgb@%0d", k), 32'({s_r, s_g, s_b}),
                (k >= 2 && c2 < 16 && r2 < 6) ? 7 : 0);
            chk($sformatf("s_hs@%0d", k), 32'(s_hs), (k >= 2 && c2 >= 18 && c2 <= 21) ? 0 : 1);
            chk($sformatf("s_vs@%0d", k), 32'(s_vs), (k >= 2 && r2 >= 7 && r2 <= 8) ? 0 : 1);
            if (s_ft) ft_cnt++;

            chk($sformatf("p_pe@%0d", k), 32'(p_pe), 1);
            chk($sformatf("p_col@%0d", k), p_col, (k - 1) % 25);
            chk($sformatf("p_row@%0d", k), p_row, ((k - 1) / 25) % 10);

`ifdef VGA_TEST_PATTERN_EN
            if (k == 180) test_mode = 1'b1;
            if (k == 200) test_mode = 1'b0;
`endif
        end

        chk("hs_width", hs_low_cnt, 192);
        chk("hs_first", hs_first, 1314);
        chk("ft_count", ft_cnt, 3);

        // Mid-frame asynchronous reset between clock edges.
        chk("pre_rst_rgb_b", 32'({b_r, b_g, b_b}), 7);
        #2 RST = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rel_col1_b", b_col, 0);
        chk("rel_pe1_b", 32'(b_pe), 1);
        @(negedge CLK);
        chk("rel_col2_b", b_col, 1);
        chk("rel_row2_b", b_row, 0);
        chk("rel_col2_s", s_col, 1);
        chk("rel_row2_s", s_row, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Upstream and downstream neighbour of the tic-tac-toe display stage.
- Generates 640x480@60 scan position (row, col, vnotactive) that the display block consumes.
- Takes back the display's registered 1-bit red/green/blue, re-aligns them with delayed sync and blanking, and drives the VGA pins.
- All pin outputs are registered; counter state is the single timing source for the frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, CLK cycles per pixel (>=1)
- DISP_LAT, 1, CLK latency of the display stage from row/col to red/green/blue
- SYNC_POL, 0, asserted level of VGA_HS/VGA_VS

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- red  in  1  pixel colour from display stage
- green  in  1  pixel colour from display stage
- blue  in  1  pixel colour from display stage
- row  out  32  current line, zero-extended v_cnt
- col  out  32  current pixel, zero-extended h_cnt
- vnotactive  out  1  high while row >= V_ACTIVE
- pix_en  out  1  one-CLK strobe per pixel
- frame_tick  out  1  one-CLK pulse when scan wraps to (0,0)
- VGA_R  out  1  registered, blanked colour
- VGA_G  out  1  registered, blanked colour
- VGA_B  out  1  registered, blanked colour
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Reset values: div_cnt, h_cnt, v_cnt = 0; row = col = 0; vnotactive = 0; pix_en = 0; frame_tick = 0; VGA_R/G/B = 0; VGA_HS = VGA_VS = ~SYNC_POL; delay pipeline cleared to blank/sync-inactive.
- Reset mid-frame takes effect immediately with no clock; the first frame after release starts at (0,0).
- Divider: div_cnt counts 0..PIX_DIV-1 and wraps. pix_en is high for the CLK in which div_cnt == PIX_DIV-1. With PIX_DIV = 1, pix_en is constantly high after reset.
- Counters advance only when pix_en is high:
  - h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0.
  - Simultaneous wrap of both is legal and produces exactly one frame_tick pulse, in the CLK the counters become (0,0).
- row/col are the counter registers themselves, no extra latency. vnotactive is registered alongside the counters and is therefore coincident with row.
- Stage 0, decode from counters:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Alignment: active/hs/vs pass through a DISP_LAT-deep shift register clocked every CLK (not only on pix_en), so they meet red/green/blue from the same row/col.
- Output register:
  - VGA_R = red & active_d; VGA_G and VGA_B likewise.
  - VGA_HS = hs_d ? SYNC_POL : ~SYNC_POL; VGA_VS likewise.
  - Counter to pin latency = DISP_LAT+1 CLK.
- During blanking, RGB is forced to 0 regardless of the inputs.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined: adds input port test_mode (1 bit).
  - test_mode = 1: the display inputs are ignored and the colour source is col[7:5] as {R,G,B}, giving 8 vertical colour bars of 32 px, repeating.
  - The pattern goes through the same DISP_LAT alignment and blanking.
  - test_mode is sampled each CLK; switching mid-line is allowed and takes effect at the next pixel.
- Undefined: no test_mode port; colour comes only from red/green/blue.

Test Plan:
- Release RST, PIX_DIV=2: col steps every 2 CLK; col 799 -> 0 with row 0 -> 1; pix_en period is 2 CLK.
- Hsync timing: with SYNC_POL=0, VGA_HS is low exactly while counter col is 656..751, seen DISP_LAT+1 = 2 CLK later; it is 96*2 = 192 CLK wide. VGA_VS is low for lines 490..491.
- Frame boundaries: vnotactive rises when row becomes 480 and falls at row 0. frame_tick pulses once every 800*525*2 = 840000 CLK.
- Blanking: hold red=green=blue=1. VGA_R/G/B are 1 for counter cols 0..639 on rows 0..479 only, and 0 from col 640 on and on every row >= 480.
- Async reset at row 300, col 200: drop RST between clock edges. All outputs go to reset values immediately. After release, counting restarts at (0,0).
- Macro defined, test_mode=1: counter col 96 gives {VGA_R,VGA_G,VGA_B} = 3'b011 two CLK later. Returning to test_mode=0 restores display colours.
